// File: rtl/noc_pkg.sv
// Shared NoC router types and helpers.
// Contents: the arbiter state enum, the widest supported port count, and a
// one-hot-to-index converter for grant vectors up to MAX_N bits wide.
package noc_pkg;

    // Widest grant vector onehot_to_idx accepts; narrower vectors are zero-extended.
    localparam int unsigned MAX_N = 64;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // ORs together the indices of all set bits, which gives the index for a one-hot input.
    function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_packet_arbiter_pick.sv
// rr_pick: combinational round-robin pick.
// Ports: req (N requests), ptr (highest-priority index) -> winner (one-hot), any.
// Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
module rr_pick #(
    parameter int unsigned N     = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             any
);

    localparam int unsigned W2 = 2 * N;

    logic [N-1:0]  lower_mask;
    logic [W2-1:0] dbl;
    logic [W2-1:0] dbl_oh;

    // Requests below ptr are masked in the low half. The unmasked copy in the
    // high half catches the wrap-around when nothing at or above ptr requests.
    always_comb begin
        lower_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            lower_mask[i] = (PTR_W'(i) < ptr);
        end
        dbl    = {req, req & ~lower_mask};
        dbl_oh = dbl & (~dbl + W2'(1));
        winner = dbl_oh[N-1:0] | dbl_oh[W2-1:N];
        any    = |req;
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: round-robin output-port arbiter with wormhole packet lock.
// Ports: clk_i, rst_i (sync, active-high); req_i/last_i per input; rdy_i from
// downstream; grant_o (registered one-hot, feeds mux select); valid_o/ack_o
// (combinational from the held grant and current req_i/rdy_i); lock_o.
// The grant is held from the head flit through the tail flit.
module rr_packet_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned IN_N = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [IN_N-1:0] req_i,
    input  logic [IN_N-1:0] last_i,
    input  logic            rdy_i,
    output logic [IN_N-1:0] grant_o,
    output logic            valid_o,
    output logic [IN_N-1:0] ack_o,
    output logic            lock_o
);

    // Derived from IN_N; IN_N must not exceed noc_pkg::MAX_N.
    localparam int unsigned PTR_W = (IN_N > 1) ? $clog2(IN_N) : 1;

    arb_state_t      state;
    logic [IN_N-1:0] grant_q;
    logic [PTR_W-1:0] ptr;

    logic [IN_N-1:0] pick_gnt;
    logic            pick_any;
    logic            xfer;
    logic            tail;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] ptr_next;

    rr_pick #(
        .N     (IN_N),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req_i),
        .ptr    (ptr),
        .winner (pick_gnt),
        .any    (pick_any)
    );

    // grant_q is zero outside LOCKED, so these are naturally inactive in IDLE.
    always_comb begin
        xfer      = (|(grant_q & req_i)) & rdy_i;
        tail      = |(grant_q & req_i & last_i);
        grant_idx = PTR_W'(onehot_to_idx(MAX_N'(grant_q)));
        ptr_next  = '0;
        if (grant_idx != PTR_W'(IN_N - 1)) begin
            ptr_next = grant_idx + PTR_W'(1);
        end
    end

    // Arbiter state: grab in IDLE, release only on a transferred tail flit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_gnt;
                        state   <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (xfer && tail) begin
                        grant_q <= '0;
                        state   <= ARB_IDLE;
                        ptr     <= ptr_next;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state   <= ARB_IDLE;
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign lock_o  = (state == ARB_LOCKED);
    assign valid_o = |(grant_q & req_i);
    assign ack_o   = grant_q & {IN_N{xfer}};

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Bench for rr_packet_arbiter (IN_N = 8). Inputs change just after the rising
// edge or on the falling edge; outputs are sampled on the falling edge.
// Expected grant winners are queued when requests are driven and popped by a
// monitor each time a new grant appears.
module tb_rr_packet_arbiter;

    localparam int unsigned IN_N = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [IN_N-1:0] req_i;
    logic [IN_N-1:0] last_i;
    logic            rdy_i;
    logic [IN_N-1:0] grant_o;
    logic            valid_o;
    logic [IN_N-1:0] ack_o;
    logic            lock_o;

    int errors = 0;
    int checks = 0;
    logic [IN_N-1:0] exp_q[$];
    logic [IN_N-1:0] prev_grant = '0;

    rr_packet_arbiter #(.IN_N(IN_N)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .last_i  (last_i),
        .rdy_i   (rdy_i),
        .grant_o (grant_o),
        .valid_o (valid_o),
        .ack_o   (ack_o),
        .lock_o  (lock_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor plus invariants, evaluated every falling edge.
    always @(negedge clk_i) begin
        if (prev_grant == '0 && grant_o != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_grant: got %h, none expected", grant_o);
            end else begin
                logic [IN_N-1:0] e;
                e = exp_q.pop_front();
                if (grant_o !== e) begin
                    errors++;
                    $display("FAIL sb_grant: got %h want %h", grant_o, e);
                end
            end
        end
        prev_grant = grant_o;
        checks++;
        if (!$onehot0(grant_o) || ((ack_o & ~grant_o) != '0) || (lock_o !== (|grant_o))) begin
            errors++;
            $display("FAIL invariant: grant=%h ack=%h lock=%b", grant_o, ack_o, lock_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic edge1();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        req_i  = '0;
        last_i = '0;
        rdy_i  = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i  = 1'b1;
        req_i  = 8'hFF;
        last_i = '0;
        rdy_i  = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (grant_o !== 8'h00 || lock_o !== 1'b0 || valid_o !== 1'b0 || ack_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: grant=%h lock=%b valid=%b ack=%h want 0", grant_o, lock_o, valid_o, ack_o);
        end
        req_i = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_single_flit();
        exp_q.push_back(8'h04);
        req_i = 8'h04; last_i = 8'h04; rdy_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (grant_o !== 8'h00) begin errors++; $display("FAIL single_c0: grant=%h want 00", grant_o); end
        edge1();
        @(negedge clk_i);
        checks++;
        if (grant_o !== 8'h04 || ack_o !== 8'h04 || valid_o !== 1'b1 || lock_o !== 1'b1) begin
            errors++;
            $display("FAIL single_c1: grant=%h ack=%h valid=%b lock=%b want 04/04/1/1", grant_o, ack_o, valid_o, lock_o);
        end
        edge1();
        req_i = '0; last_i = '0;
        @(negedge clk_i);
        checks++;
        if (lock_o !== 1'b0 || grant_o !== 8'h00) begin errors++; $display("FAIL single_c2: lock=%b grant=%h want 0", lock_o, grant_o); end
        // ptr is now 3: with inputs 2 and 3 requesting, 3 must win.
        exp_q.push_back(8'h08);
        req_i = 8'h0C; last_i = 8'h0C;
        edge1();
        @(negedge clk_i);
        checks++;
        if (grant_o !== 8'h08) begin errors++; $display("FAIL single_ptr3: grant=%h want 08", grant_o); end
        edge1();
        req_i = '0; last_i = '0;
    endtask

    task automatic test_wormhole();
        // ptr = 4: input 5 wins over input 1 and holds for 3 flits.
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h02);
        req_i = 8'h22; last_i = 8'h00; rdy_i = 1'b1;
        edge1();
        for (int f = 0; f < 3; f++) begin
            if (f == 2) last_i = 8'h20;
            @(negedge clk_i);
            checks++;
            if (grant_o !== 8'h20 || ack_o !== 8'h20) begin
                errors++;
                $display("FAIL worm_flit%0d: grant=%h ack=%h want 20/20", f, grant_o, ack_o);
            end
            edge1();
        end
        req_i = 8'h02; last_i = 8'h02;
        @(negedge clk_i);
        checks++;
        if (grant_o !== 8'h00 || lock_o !== 1'b0) begin errors++; $display("FAIL worm_bubble: grant=%h lock=%b want 00/0", grant_o, lock_o); end
        edge1();
        @(negedge clk_i);
        checks++;
        if (grant_o !== 8'h02 || ack_o !== 8'h02) begin errors++; $display("FAIL worm_next: grant=%h ack=%h want 02/02", grant_o, ack_o); end
        edge1();
        req_i = '0; last_i = '0;
        @(negedge clk_i);
    endtask

    task automatic test_round_robin();
        logic [IN_N-1:0] e;
        do_reset();
        for (int k = 0; k < 9; k++) exp_q.push_back(8'(1 << (k % 8)));
        req_i = 8'hFF; last_i = 8'hFF; rdy_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            e = 8'(1 << (k % 8));
            edge1();
            @(negedge clk_i);
            checks++;
            if (grant_o !== e) begin errors++; $display("FAIL rr_grant%0d: grant=%h want %h", k, grant_o, e); end
            edge1();
            @(negedge clk_i);
            checks++;
            if (grant_o !== 8'h00) begin errors++; $display("FAIL rr_bubble%0d: grant=%h want 00", k, grant_o); end
        end
        req_i = '0; last_i = '0;
    endtask

    task automatic test_upstream_bubble();
        // ptr = 1: input 2 is the only requester.
        exp_q.push_back(8'h04);
        req_i = 8'h04; last_i = 8'h00; rdy_i = 1'b1;
        edge1();
        @(negedge clk_i);
        checks++;
        if (ack_o !== 8'h04) begin errors++; $display("FAIL bub_head: ack=%h want 04", ack_o); end
        edge1();
        req_i = 8'h00;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            checks++;
            if (grant_o !== 8'h04 || valid_o !== 1'b0 || ack_o !== 8'h00 || lock_o !== 1'b1) begin
                errors++;
                $display("FAIL bub_gap%0d: grant=%h valid=%b ack=%h lock=%b want 04/0/00/1", c, grant_o, valid_o, ack_o, lock_o);
            end
            edge1();
        end
        req_i = 8'h04; last_i = 8'h04;
        @(negedge clk_i);
        checks++;
        if (ack_o !== 8'h04 || valid_o !== 1'b1) begin errors++; $display("FAIL bub_tail: ack=%h valid=%b want 04/1", ack_o, valid_o); end
        edge1();
        req_i = '0; last_i = '0;
        @(negedge clk_i);
        checks++;
        if (lock_o !== 1'b0) begin errors++; $display("FAIL bub_release: lock=%b want 0", lock_o); end
    endtask

    task automatic test_stall();
        // ptr = 3: input 7 packet, downstream stalls for 4 cycles.
        exp_q.push_back(8'h80);
        req_i = 8'h80; last_i = 8'h00; rdy_i = 1'b1;
        edge1();
        @(negedge clk_i);
        checks++;
        if (ack_o !== 8'h80) begin errors++; $display("FAIL stall_head: ack=%h want 80", ack_o); end
        edge1();
        rdy_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            checks++;
            if (grant_o !== 8'h80 || ack_o !== 8'h00 || valid_o !== 1'b1) begin
                errors++;
                $display("FAIL stall_c%0d: grant=%h ack=%h valid=%b want 80/00/1", c, grant_o, ack_o, valid_o);
            end
            edge1();
        end
        rdy_i = 1'b1; last_i = 8'h80;
        @(negedge clk_i);
        checks++;
        if (ack_o !== 8'h80) begin errors++; $display("FAIL stall_tail: ack=%h want 80", ack_o); end
        edge1();
        // ptr wrapped to 0: input 0 beats input 6, then 6 follows after a bubble.
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h40);
        req_i = 8'h41; last_i = 8'h41;
        edge1();
        @(negedge clk_i);
        checks++;
        if (grant_o !== 8'h01) begin errors++; $display("FAIL stall_wrap: grant=%h want 01", grant_o); end
        edge1();
        req_i = 8'h40; last_i = 8'h40;
        edge1();
        @(negedge clk_i);
        checks++;
        if (grant_o !== 8'h40) begin errors++; $display("FAIL stall_next: grant=%h want 40", grant_o); end
        edge1();
        req_i = '0; last_i = '0;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_packet();
        // ptr = 7: input 3 wins, then reset lands mid-packet.
        exp_q.push_back(8'h08);
        req_i = 8'h08; last_i = 8'h00; rdy_i = 1'b1;
        edge1();
        @(negedge clk_i);
        checks++;
        if (grant_o !== 8'h08) begin errors++; $display("FAIL rmid_grant: grant=%h want 08", grant_o); end
        edge1();
        rst_i = 1'b1; last_i = 8'h08;
        edge1();
        rst_i = 1'b0;
        // Inputs 6 and 7 request: ptr back at 0 must pick 6 (a stale ptr 7 would pick 7).
        exp_q.push_back(8'h40);
        req_i = 8'hC0; last_i = 8'hC0;
        @(negedge clk_i);
        checks++;
        if (grant_o !== 8'h00 || lock_o !== 1'b0) begin errors++; $display("FAIL rmid_flush: grant=%h lock=%b want 00/0", grant_o, lock_o); end
        edge1();
        @(negedge clk_i);
        checks++;
        if (grant_o !== 8'h40) begin errors++; $display("FAIL rmid_regrant: grant=%h want 40", grant_o); end
        req_i = 8'h40; last_i = 8'h40;
        edge1();
        req_i = '0; last_i = '0;
        @(negedge clk_i);
        checks++;
        if (lock_o !== 1'b0) begin errors++; $display("FAIL rmid_release: lock=%b want 0", lock_o); end
    endtask

    initial begin
        rst_i = 1'b1; req_i = '0; last_i = '0; rdy_i = 1'b1;
        test_reset();
        test_single_flit();
        test_wormhole();
        test_round_robin();
        test_upstream_bubble();
        test_stall();
        test_reset_mid_packet();
        repeat (2) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected grants never seen, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Round-robin arbiter with wormhole packet lock, placed directly upstream of the router's one-hot output mux (mux_Nx1).
- Chooses one of IN_N input ports competing for one output port and drives the mux select with a registered one-hot grant.
- Holds the grant from the head flit through the tail flit, so flits of different packets never interleave on the output.
- Provides the per-input ready/ack back to the input buffers.

Parameters:
- IN_N, 8, number of competing input ports; must be >= 1.
- PTR_W, $clog2(IN_N) (min 1), width of the round-robin pointer; derived, do not override.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  IN_N  per-input "flit valid and routed to this output".
- last_i  input  IN_N  per-input tail-flit flag; qualified by req_i.
- rdy_i  input  1  downstream (output buffer / link) ready.
- grant_o  output  IN_N  registered one-hot grant; connects to mux sel_i.
- valid_o  output  1  output flit valid = req_i[granted] while locked.
- ack_o  output  IN_N  per-input pop strobe; one-hot or zero.
- lock_o  output  1  high while in LOCKED (packet in flight).

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - grant_o = 0, lock_o = 0, valid_o = 0, ack_o = 0.
  - Round-robin pointer ptr = 0.
  - State = IDLE.
- State machine, two states:
  - IDLE: grant_o = 0, valid_o = 0, ack_o = 0.
    - If |req_i, pick the first i with req_i[i] = 1, searching ptr, ptr+1, …, IN_N-1, 0, …, ptr-1.
    - On the next edge: grant_q <= onehot(i), state <= LOCKED.
    - If req_i = 0, stay in IDLE.
  - LOCKED: grant_o = grant_q (exactly one bit set). Let g be the index of that bit.
    - valid_o = req_i[g].
    - ack_o = grant_q & {IN_N{req_i[g] & rdy_i}}.
    - Transfer happens when req_i[g] & rdy_i.
    - Transfer with last_i[g] = 1: on the next edge, state <= IDLE, grant_q <= 0, ptr <= (g+1) mod IN_N (wrap IN_N-1 -> 0).
    - Transfer with last_i[g] = 0: stay LOCKED.
    - No transfer: stay LOCKED, grant unchanged.
- Latency:
  - req in IDLE at cycle n -> grant_o valid at n+1.
  - First transfer is possible at n+1.
  - The release edge always leaves one IDLE cycle (bubble) before the next grant. This is intentional: the grant is registered.
- Lock rules:
  - The granted input dropping req_i mid-packet (upstream bubble) does NOT release the lock. valid_o = 0 for that cycle.
  - Requests from other inputs are ignored while LOCKED.
  - last_i on non-granted inputs is ignored.
  - last_i with req_i[g] = 0 is ignored.
- Single-flit packet (head = tail, last_i = 1 on first transfer): one transfer cycle, then release.
- rdy_i held low while locked: grant, valid_o and the stall are held indefinitely. There is no timeout.
- Simultaneous rst_i with a transfer: reset wins. Lock dropped, ptr = 0.
- Reset mid-packet: the arbiter forgets the packet. Flushing upstream/downstream is the router's responsibility.
- Fairness: the winner of the last packet becomes lowest priority. Every persistent requester is served within IN_N packets.
- IN_N = 1: degenerates to lock/unlock on input 0. ptr stays 0.
- Invariants:
  - $onehot0(grant_o) always.
  - ack_o is a subset of grant_o.
  - lock_o == |grant_o.

Decomposition:
- noc_pkg:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t.
  - Helper function onehot_to_idx.
- Sub-module rr_pick, combinational, in the same file or components/:
  - Inputs: req, ptr.
  - Outputs: one-hot winner and any.
  - Implemented with the double-width request mask / find-first-set trick.
  - Reused by other output ports' arbiters.
- Everything else (state, ptr, grant_q) lives in rr_packet_arbiter.

Test Plan:
- Reset, then req_i = 8'b0000_0100, last_i = 8'b0000_0100, rdy_i = 1 -> grant_o = 8'h04 at cycle 1; ack_o = 8'h04 at cycle 1; lock_o falls at cycle 2; ptr = 3.
- 3-flit packet on input 5 (last_i[5] only on the 3rd flit), rdy_i = 1, while input 1 also requests -> grant_o stays 8'h20 for 3 cycles. Input 1 is granted only after one IDLE cycle. ack_o[1] = 0 throughout.
- All 8 inputs request continuously with single-flit packets, from reset -> grant order 0,1,2,…,7,0, each grant followed by one IDLE cycle. There are no repeats before wrap.
- Granted input 2 drops req_i for 2 cycles mid-packet, with rdy_i = 1 -> valid_o = 0 and ack_o = 0 for those cycles. grant_o stays 8'h04. The packet resumes and completes on last_i[2].
- rdy_i = 0 for 4 cycles during a locked packet on input 7 -> grant_o = 8'h80 held, ack_o = 0, valid_o = 1. When rdy_i is released, transfers resume. After the tail, ptr wraps to 0.
- Assert rst_i mid-packet on input 3 -> next cycle grant_o = 0, lock_o = 0. A new request on input 6 is granted one cycle after rst_i deasserts (ptr = 0 search).
